// File: rtl/cpu_multicycle_param.sv
// Multicycle FETCH/EXEC/WB core with configurable data width and register count.
// Fetches through a request/valid handshake; reports halt and undefined opcodes.
module cpu_multicycle_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned REG_COUNT = 8,
    parameter logic [31:0] RESET_PC  = '0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       INSTRUCTION,
    input  logic              INSTR_VALID,
    output logic [31:0]       PC,
    output logic              INSTR_REQ,
    output logic              WB_EN,
    output logic [DATA_W-1:0] RESULT,
    output logic              HALTED,
    output logic              ILLEGAL
);

    localparam int unsigned RA_W = $clog2(REG_COUNT);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WB, S_HALT} state_t;
    typedef enum logic [7:0] {
        OP_LOADI = 8'h00, OP_MOV = 8'h01, OP_ADD = 8'h02, OP_SUB = 8'h03,
        OP_AND   = 8'h04, OP_OR  = 8'h05, OP_J   = 8'h06, OP_BEQ = 8'h07,
        OP_HALT  = 8'h08
    } opcode_t;

    state_t            state, state_next;
    logic [31:0]       ir;
    logic [31:0]       next_pc;
    logic [DATA_W-1:0] regs [REG_COUNT];

    logic [RA_W-1:0]   rd, rs1, rs2;
    logic [DATA_W-1:0] a, b, imm, alu;
    logic [31:0]       seq_pc, target, exec_pc;
    logic              is_alu, is_halt, is_ill;
    logic              fetch_ok;
    logic              unused_ir;

    assign rd        = ir[16 +: RA_W];
    assign rs1       = ir[8 +: RA_W];
    assign rs2       = ir[0 +: RA_W];
    assign a         = regs[rs1];
    assign b         = regs[rs2];
    assign imm       = DATA_W'($signed(ir[7:0]));
    assign seq_pc    = PC + 32'd4;
    assign target    = seq_pc + (32'($signed(ir[23:16])) << 2);
    assign fetch_ok  = INSTR_REQ && INSTR_VALID;
    assign unused_ir = ^ir;

    always_comb begin
        is_alu  = 1'b0;
        is_halt = 1'b0;
        is_ill  = 1'b0;
        alu     = '0;
        exec_pc = seq_pc;
        case (ir[31:24])
            OP_LOADI: begin alu = imm;   is_alu = 1'b1; end
            OP_MOV:   begin alu = b;     is_alu = 1'b1; end
            OP_ADD:   begin alu = a + b; is_alu = 1'b1; end
            OP_SUB:   begin alu = a - b; is_alu = 1'b1; end
            OP_AND:   begin alu = a & b; is_alu = 1'b1; end
            OP_OR:    begin alu = a | b; is_alu = 1'b1; end
            OP_J:     exec_pc = target;
            OP_BEQ:   if (a == b) exec_pc = target;
            OP_HALT:  begin is_halt = 1'b1; exec_pc = PC; end
            default:  is_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: if (fetch_ok) state_next = S_EXEC;
            S_EXEC:  state_next = S_WB;
            S_WB:    state_next = HALTED ? S_HALT : S_FETCH;
            default: state_next = S_HALT;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_FETCH;
        else       state <= state_next;
    end

    // EXEC registers the outcome into WB_EN/ILLEGAL/RESULT/next_pc; the WB edge commits PC and rd.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            PC        <= RESET_PC;
            ir        <= '0;
            next_pc   <= '0;
            INSTR_REQ <= 1'b0;
            WB_EN     <= 1'b0;
            RESULT    <= '0;
            HALTED    <= 1'b0;
            ILLEGAL   <= 1'b0;
            for (int unsigned i = 0; i < REG_COUNT; i++) regs[RA_W'(i)] <= '0;
        end else begin
            INSTR_REQ <= (state_next == S_FETCH);
            WB_EN     <= 1'b0;
            ILLEGAL   <= 1'b0;
            case (state)
                S_FETCH: if (fetch_ok) ir <= INSTRUCTION;
                S_EXEC: begin
                    WB_EN   <= is_alu;
                    ILLEGAL <= is_ill;
                    HALTED  <= HALTED | is_halt;
                    next_pc <= exec_pc;
                    if (is_alu) RESULT <= alu;
                end
                S_WB: begin
                    PC <= next_pc;
                    if (WB_EN) regs[rd] <= RESULT;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_multicycle_param.sv
// Randomised bench for cpu_multicycle_param: two lanes (8-bit and 16-bit cores) checked every
// cycle against an instruction-level reference model, plus literal expectations for directed programs.
module tb_cpu_multicycle_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst;
    logic [1:0]  valid;
    logic [31:0] instr [2];
    wire  [31:0] pc0, pc1;
    wire  [1:0]  req, wb, halt, ill;
    wire  [7:0]  res0;
    wire  [15:0] res1;

    cpu_multicycle_param #(.DATA_W(8), .REG_COUNT(8), .RESET_PC(32'h0)) dut0 (
        .CLK(clk), .RESET(rst[0]), .INSTRUCTION(instr[0]), .INSTR_VALID(valid[0]),
        .PC(pc0), .INSTR_REQ(req[0]), .WB_EN(wb[0]), .RESULT(res0),
        .HALTED(halt[0]), .ILLEGAL(ill[0]));

    cpu_multicycle_param #(.DATA_W(16), .REG_COUNT(4), .RESET_PC(32'h40)) dut1 (
        .CLK(clk), .RESET(rst[1]), .INSTRUCTION(instr[1]), .INSTR_VALID(valid[1]),
        .PC(pc1), .INSTR_REQ(req[1]), .WB_EN(wb[1]), .RESULT(res1),
        .HALTED(halt[1]), .ILLEGAL(ill[1]));

    int unsigned lw   [2] = '{8, 16};
    int unsigned lrc  [2] = '{8, 4};
    logic [31:0] lrpc [2] = '{32'h0, 32'h40};

    // reference model and per-cycle expectations
    logic [31:0] m_pc  [2];
    logic [31:0] m_reg [2][256];
    logic [31:0] e_pc  [2];
    logic [31:0] e_res [2];
    logic        e_req [2], e_wb [2], e_halt [2], e_ill [2];

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [31:0] a_pc(input int l);
        return (l == 0) ? pc0 : pc1;
    endfunction

    function automatic logic [31:0] a_res(input int l);
        return (l == 0) ? {24'b0, res0} : {16'b0, res1};
    endfunction

    task automatic chk(input string nm, input int l, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s lane%0d: got %h expected %h at %0t", nm, l, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int l = 0; l < 2; l++) begin
            chk("pc",        l, a_pc(l),       e_pc[l]);
            chk("instr_req", l, 32'(req[l]),   32'(e_req[l]));
            chk("wb_en",     l, 32'(wb[l]),    32'(e_wb[l]));
            chk("result",    l, a_res(l),      e_res[l]);
            chk("halted",    l, 32'(halt[l]),  32'(e_halt[l]));
            chk("illegal",   l, 32'(ill[l]),   32'(e_ill[l]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reset_exp(input int l);
        e_pc[l] = lrpc[l]; e_res[l] = '0;
        e_req[l] = 1'b0; e_wb[l] = 1'b0; e_halt[l] = 1'b0; e_ill[l] = 1'b0;
        m_pc[l] = lrpc[l];
        for (int i = 0; i < 256; i++) m_reg[l][i] = '0;
    endtask

    task automatic park(input int l);
        rst[l] = 1'b1; valid[l] = 1'b0;
        set_reset_exp(l);
    endtask

    // Entered at posedge+1; reset is raised mid-cycle and its effect checked before any edge.
    task automatic do_reset(input int l);
        #1;
        park(l);
        #1;
        chk("async_rst_pc",   l, a_pc(l),      lrpc[l]);
        chk("async_rst_req",  l, 32'(req[l]),  32'd0);
        chk("async_rst_halt", l, 32'(halt[l]), 32'd0);
        chk("async_rst_res",  l, a_res(l),     32'd0);
        tick();
        rst[l] = 1'b0;
        tick();
        e_req[l] = 1'b1;
    endtask

    // Entered at posedge+1 in FETCH; returns at posedge+1 back in FETCH (or in HALT).
    task automatic exec(input int l, input logic [31:0] ins, input int unsigned k);
        logic [31:0] mask, rcm, a, b, imm, off, v, npc;
        logic [7:0]  op;
        int unsigned d, s1, s2;
        logic        alu, illg, hlt;
        repeat (k) begin
            valid[l] = 1'b0; instr[l] = $urandom;
            tick();
        end
        valid[l] = 1'b1; instr[l] = ins;
        tick();
        valid[l] = 1'($urandom_range(0, 1)); instr[l] = $urandom;
        e_req[l] = 1'b0;
        mask = 32'hFFFF_FFFF >> (32 - lw[l]);
        rcm  = lrc[l] - 1;
        op = ins[31:24];
        d  = ins[23:16] & rcm;
        s1 = ins[15:8] & rcm;
        s2 = ins[7:0] & rcm;
        a  = m_reg[l][s1];
        b  = m_reg[l][s2];
        imm = (ins[7] ? (32'hFFFF_FF00 | {24'b0, ins[7:0]}) : {24'b0, ins[7:0]}) & mask;
        off = {{22{ins[23]}}, ins[23:16], 2'b00};
        alu = 1'b0; illg = 1'b0; hlt = 1'b0; v = '0;
        npc = m_pc[l] + 32'd4;
        case (op)
            8'h00: begin v = imm;            alu = 1'b1; end
            8'h01: begin v = b;              alu = 1'b1; end
            8'h02: begin v = (a + b) & mask; alu = 1'b1; end
            8'h03: begin v = (a - b) & mask; alu = 1'b1; end
            8'h04: begin v = a & b;          alu = 1'b1; end
            8'h05: begin v = a | b;          alu = 1'b1; end
            8'h06: npc = npc + off;
            8'h07: if (a == b) npc = npc + off;
            8'h08: hlt = 1'b1;
            default: illg = 1'b1;
        endcase
        tick();
        valid[l] = 1'($urandom_range(0, 1)); instr[l] = $urandom;
        e_wb[l] = alu; e_ill[l] = illg;
        if (alu) e_res[l] = v;
        if (hlt) e_halt[l] = 1'b1;
        tick();
        e_wb[l] = 1'b0; e_ill[l] = 1'b0;
        if (!hlt) begin
            e_req[l] = 1'b1;
            m_pc[l] = npc; e_pc[l] = npc;
            if (alu) m_reg[l][d] = v;
        end
    endtask

    function automatic logic [31:0] enc(input logic [7:0] op, input logic [7:0] d,
                                        input logic [7:0] s1, input logic [7:0] s2);
        return {op, d, s1, s2};
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [7:0]  op;
        int unsigned r;
        r = $urandom_range(0, 19);
        if (r < 16) op = 8'(r % 8);
        else        op = 8'($urandom_range(9, 255));
        return {op, 8'($urandom), 8'($urandom), 8'($urandom)};
    endfunction

    initial begin
        rst = '1; valid = '0;
        instr[0] = '0; instr[1] = '0;
        set_reset_exp(0);
        set_reset_exp(1);
        tick(); tick();

        // lane 0: DATA_W=8, REG_COUNT=8, RESET_PC=0
        do_reset(0);
        exec(0, enc(8'h00, 8'd4, 8'd0, 8'h05), 0); chk("lit_loadi_r4", 0, a_res(0), 32'h05);
        exec(0, enc(8'h00, 8'd2, 8'd0, 8'h09), 0); chk("lit_loadi_r2", 0, a_res(0), 32'h09);
        exec(0, enc(8'h03, 8'd3, 8'd2, 8'd4), 0);  chk("lit_sub", 0, a_res(0), 32'h04);
        chk("lit_pc_12", 0, a_pc(0), 32'd12);
        exec(0, enc(8'h00, 8'd1, 8'd0, 8'h7F), 0);
        exec(0, enc(8'h00, 8'd2, 8'd0, 8'h01), 0);
        exec(0, enc(8'h02, 8'd0, 8'd1, 8'd2), 0);  chk("lit_add_wrap", 0, a_res(0), 32'h80);
        exec(0, enc(8'h01, 8'd6, 8'd0, 8'd0), 5);  chk("lit_mov_slow", 0, a_res(0), 32'h80);

        do_reset(0);
        exec(0, enc(8'h00, 8'd1, 8'd0, 8'h03), 0);
        exec(0, enc(8'h00, 8'd2, 8'd0, 8'h07), 0);
        exec(0, enc(8'h07, 8'h02, 8'd1, 8'd2), 0); chk("lit_beq_ne", 0, a_pc(0), 32'd12);
        exec(0, enc(8'h06, 8'hFE, 8'd0, 8'd0), 0); chk("lit_j_back", 0, a_pc(0), 32'd8);
        exec(0, enc(8'h07, 8'h02, 8'd1, 8'd1), 0); chk("lit_beq_eq", 0, a_pc(0), 32'd20);
        chk("lit_beq_nowb", 0, a_res(0), 32'h07);
        exec(0, enc(8'h06, 8'hFE, 8'd0, 8'd0), 0); chk("lit_j_16", 0, a_pc(0), 32'd16);
        exec(0, enc(8'h06, 8'hFF, 8'd0, 8'd0), 0); chk("lit_j_self", 0, a_pc(0), 32'd16);
        exec(0, enc(8'h3C, 8'd1, 8'd2, 8'd3), 0);  chk("lit_illegal_pc", 0, a_pc(0), 32'd20);
        exec(0, enc(8'h08, 8'd0, 8'd0, 8'd0), 0);
        repeat (20) begin
            valid[0] = 1'($urandom_range(0, 1)); instr[0] = $urandom;
            tick();
        end
        chk("lit_halted", 0, 32'(halt[0]), 32'd1);
        chk("lit_halt_req", 0, 32'(req[0]), 32'd0);
        chk("lit_halt_pc", 0, a_pc(0), 32'd20);
        do_reset(0);
        chk("lit_halt_cleared", 0, 32'(halt[0]), 32'd0);

        exec(0, enc(8'h00, 8'd3, 8'd0, 8'h11), 1);
        valid[0] = 1'b0;
        tick(); tick();
        do_reset(0);

        repeat (300) exec(0, rnd_instr(), $urandom_range(0, 3));
        exec(0, enc(8'h08, 8'd0, 8'd0, 8'd0), 1);
        repeat (3) tick();
        park(0);
        tick();

        // lane 1: DATA_W=16, REG_COUNT=4 (register fields alias modulo 4), RESET_PC=0x40
        do_reset(1);
        exec(1, enc(8'h00, 8'd5, 8'd0, 8'hFF), 0); chk("lit_sext16", 1, a_res(1), 32'hFFFF);
        chk("lit_pc_44", 1, a_pc(1), 32'h44);
        exec(1, enc(8'h01, 8'd2, 8'd0, 8'd5), 2);  chk("lit_mov_alias", 1, a_res(1), 32'hFFFF);
        exec(1, enc(8'h02, 8'd3, 8'd5, 8'd2), 0);  chk("lit_add16_wrap", 1, a_res(1), 32'hFFFE);
        repeat (300) exec(1, rnd_instr(), $urandom_range(0, 3));
        exec(1, enc(8'h08, 8'd0, 8'd0, 8'd0), 0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
